// File: rtl/lr_intctl_if.sv
// CPU-side bus and interrupt handshake bundle for lr_intctl.
// master = CPU, slave = interrupt controller.
interface lr_intctl_if;
    logic [15:0] address;
    logic [7:0]  wdata;
    logic        load;
    logic        store;
    logic [7:0]  rdata;
    logic        hit;
    logic        intreq;
    logic [15:0] intaddress;
    logic        intack;

    modport master (
        output address, wdata, load, store, intack,
        input  rdata, hit, intreq, intaddress
    );

    modport slave (
        input  address, wdata, load, store, intack,
        output rdata, hit, intreq, intaddress
    );
endinterface

// File: rtl/lr_intctl.sv
// DMG interrupt controller: edge-captures five sources into IF, masks
// with IE, and hands the highest-priority vector to the CPU.
// Ports: clock4/resetn (sync, active low), src[4:0] source levels,
//        bus (slave): IF/IE register access plus intreq/intaddress/intack.
module lr_intctl #(
    parameter logic [15:0] IF_ADDR  = 16'hff0f,
    parameter logic [15:0] IE_ADDR  = 16'hffff,
    parameter logic [15:0] VEC_BASE = 16'h0040
) (
    input  logic        clock4,
    input  logic        resetn,
    input  logic [4:0]  src,
    lr_intctl_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic [4:0]  src_q;
    logic        intreq_q;
    logic [15:0] intaddr_q;

    logic [4:0]  rise;
    logic [4:0]  pending;
    logic [4:0]  ackclr;
    logic [2:0]  prio;
    logic        if_wr;
    logic        ie_wr;

    always_comb begin
        if_wr   = bus.store && (bus.address == IF_ADDR);
        ie_wr   = bus.store && (bus.address == IE_ADDR);
        rise    = src & ~src_q;
        pending = if_q & ie_q[4:0];
        ackclr  = '0;
        if ((state_q == REQ) && bus.intack)
            ackclr = 5'b00001 << idx_q;
        // Edge beats ack clear beats CPU write, so no event is lost.
        if_d = ((if_wr ? bus.wdata[4:0] : if_q) & ~ackclr) | rise;
        ie_d = ie_wr ? bus.wdata : ie_q;
    end

    // Lowest set bit wins: scan from the top so bit 0 overrides.
    always_comb begin
        prio = '0;
        for (int i = 4; i >= 0; i--) begin
            if (pending[i])
                prio = 3'(i);
        end
    end

    always_comb begin
        bus.rdata = '0;
        bus.hit   = 1'b0;
        if (bus.load) begin
            if (bus.address == IF_ADDR) begin
                bus.hit   = 1'b1;
                bus.rdata = {3'b111, if_q};
            end else if (bus.address == IE_ADDR) begin
                bus.hit   = 1'b1;
                bus.rdata = ie_q;
            end
        end
    end

    always_ff @(posedge clock4) begin
        if (!resetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            if_q      <= '0;
            ie_q      <= '0;
            src_q     <= '0;
            intreq_q  <= 1'b0;
            intaddr_q <= VEC_BASE;
        end else begin
            src_q <= src;
            if_q  <= if_d;
            ie_q  <= ie_d;
            unique case (state_q)
                IDLE: begin
                    if (|pending) begin
                        state_q   <= REQ;
                        idx_q     <= prio;
                        intreq_q  <= 1'b1;
                        intaddr_q <= VEC_BASE + {10'd0, prio, 3'b000};
                    end
                end
                REQ: begin
                    // idx stays locked; leave on ack or when the
                    // locked source is no longer pending.
                    if (bus.intack || !pending[idx_q]) begin
                        state_q  <= IDLE;
                        intreq_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    intreq_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intreq     = intreq_q;
    assign bus.intaddress = intaddr_q;

endmodule

// File: tb/tb_lr_intctl.sv
// Randomized self-checking bench for lr_intctl against a
// cycle-level behavioural model of the interrupt rules.
module tb_lr_intctl;

    logic       clock4 = 1'b0;
    logic       resetn;
    logic [4:0] src;

    lr_intctl_if bus ();

    lr_intctl dut (
        .clock4 (clock4),
        .resetn (resetn),
        .src    (src),
        .bus    (bus)
    );

    always #5 clock4 = ~clock4;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: IF/IE contents, previous source levels, and which
    // source is currently locked toward the CPU (-1 when none).
    logic [4:0] m_if;
    logic [4:0] m_srcq;
    logic [7:0] m_ie;
    int         m_lock  = -1;
    bit         m_valid = 0;

    always @(posedge clock4) begin : model_b
        logic [4:0] rise, pend, nif;
        logic [7:0] nie;
        bit         ack;
        int         nlock;
        if (!resetn) begin
            m_if    = '0;
            m_ie    = '0;
            m_srcq  = '0;
            m_lock  = -1;
            m_valid = 1;
        end else if (m_valid) begin
            rise  = src & ~m_srcq;
            pend  = m_if & m_ie[4:0];
            ack   = (m_lock >= 0) && bus.intack;
            nif   = (bus.store && bus.address == 16'hff0f) ?
                    bus.wdata[4:0] : m_if;
            if (ack)
                nif[m_lock] = 1'b0;
            nif   = nif | rise;
            nie   = (bus.store && bus.address == 16'hffff) ?
                    bus.wdata : m_ie;
            nlock = m_lock;
            if (m_lock < 0) begin
                for (int i = 0; i < 5; i++) begin
                    if (pend[i]) begin
                        nlock = i;
                        break;
                    end
                end
            end else if (ack || !pend[m_lock]) begin
                nlock = -1;
            end
            m_if   = nif;
            m_ie   = nie;
            m_srcq = src;
            m_lock = nlock;
        end
    end

    always @(negedge clock4) begin : cmp_b
        logic       ehit;
        logic [7:0] edata;
        if (m_valid) begin
            check("intreq", {15'd0, bus.intreq}, {15'd0, m_lock >= 0});
            if (m_lock >= 0)
                check("intaddress", bus.intaddress,
                      16'h0040 + 16'(8 * m_lock));
            ehit  = bus.load && (bus.address == 16'hff0f ||
                                 bus.address == 16'hffff);
            edata = 8'h00;
            if (ehit)
                edata = (bus.address == 16'hff0f) ? {3'b111, m_if} : m_ie;
            check("hit", {15'd0, bus.hit}, {15'd0, ehit});
            check("rdata", {8'd0, bus.rdata}, {8'd0, edata});
        end
    end

    task automatic cyc();
        @(posedge clock4);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        bus.load    = 1'b1;
        bus.address = a;
        @(negedge clock4);
        d = bus.rdata;
        cyc();
        bus.load    = 1'b0;
        bus.address = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v);
        bus.store   = 1'b1;
        bus.address = a;
        bus.wdata   = v;
        cyc();
        bus.store   = 1'b0;
        bus.address = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    task automatic ack();
        bus.intack = 1'b1;
        cyc();
        bus.intack = 1'b0;
    endtask

    logic [7:0] d;

    initial begin
        resetn      = 1'b0;
        src         = '0;
        bus.address = '0;
        bus.wdata   = '0;
        bus.load    = 1'b0;
        bus.store   = 1'b0;
        bus.intack  = 1'b0;
        do_reset();

        check("rst_intreq", {15'd0, bus.intreq}, 16'd0);
        check("rst_vec", bus.intaddress, 16'h0040);
        rd(16'hff0f, d);
        check("rst_if", {8'd0, d}, 16'h00e0);
        rd(16'hffff, d);
        check("rst_ie", {8'd0, d}, 16'h0000);

        wr(16'hffff, 8'h04);
        src = 5'b00100;
        cyc();
        check("s2_wait", {15'd0, bus.intreq}, 16'd0);
        cyc();
        check("s2_req", {15'd0, bus.intreq}, 16'd1);
        check("s2_vec", bus.intaddress, 16'h0050);
        ack();
        check("s2_drop", {15'd0, bus.intreq}, 16'd0);
        src = '0;
        rd(16'hff0f, d);
        check("s2_if", {8'd0, d}, 16'h00e0);

        wr(16'hffff, 8'h1f);
        src = 5'b10000;
        cyc();
        cyc();
        check("s3_vec", bus.intaddress, 16'h0060);
        src = 5'b10001;
        cyc();
        check("s3_lock1", bus.intaddress, 16'h0060);
        cyc();
        check("s3_lock2", bus.intaddress, 16'h0060);
        ack();
        check("s3_gap", {15'd0, bus.intreq}, 16'd0);
        cyc();
        check("s3_req0", {15'd0, bus.intreq}, 16'd1);
        check("s3_vec0", bus.intaddress, 16'h0040);
        ack();
        src = '0;

        wr(16'hffff, 8'h01);
        src = 5'b00001;
        cyc();
        src = '0;
        cyc();
        check("s4_req", {15'd0, bus.intreq}, 16'd1);
        wr(16'hffff, 8'h00);
        check("s4_hold", {15'd0, bus.intreq}, 16'd1);
        cyc();
        check("s4_drop", {15'd0, bus.intreq}, 16'd0);
        rd(16'hff0f, d);
        check("s4_if", {8'd0, d}, 16'h00e1);

        do_reset();
        wr(16'hffff, 8'h02);
        src = 5'b00010;
        cyc();
        src = '0;
        cyc();
        check("s5_vec", bus.intaddress, 16'h0048);
        src        = 5'b00010;
        bus.intack = 1'b1;
        cyc();
        bus.intack = 1'b0;
        check("s5_gap", {15'd0, bus.intreq}, 16'd0);
        rd(16'hff0f, d);
        check("s5_if", {8'd0, d}, 16'h00e2);
        check("s5_rereq", {15'd0, bus.intreq}, 16'd1);
        check("s5_revec", bus.intaddress, 16'h0048);
        ack();
        bus.store   = 1'b1;
        bus.address = 16'hff0f;
        bus.wdata   = 8'h00;
        src         = 5'b01010;
        cyc();
        bus.store   = 1'b0;
        rd(16'hff0f, d);
        check("s5_wr_edge", {8'd0, d}, 16'h00e8);

        do_reset();
        src = 5'b00100;
        repeat (20) cyc();
        rd(16'hff0f, d);
        check("s6_once", {8'd0, d}, 16'h00e4);
        wr(16'hff0f, 8'h00);
        repeat (5) cyc();
        rd(16'hff0f, d);
        check("s6_clear", {8'd0, d}, 16'h00e0);
        check("s6_noreq", {15'd0, bus.intreq}, 16'd0);
        src = '0;

        repeat (3000) begin
            resetn = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0)
                src = src ^ 5'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0:       bus.address = 16'hff0f;
                1:       bus.address = 16'hffff;
                2:       bus.address = 16'hff0e;
                default: bus.address = 16'($urandom);
            endcase
            bus.wdata  = 8'($urandom);
            bus.store  = ($urandom_range(0, 4) == 0);
            bus.load   = ($urandom_range(0, 1) == 1);
            bus.intack = ($urandom_range(0, 3) == 0);
            cyc();
        end
        bus.store  = 1'b0;
        bus.load   = 1'b0;
        bus.intack = 1'b0;
        resetn     = 1'b1;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
